nco_sweep_ctrl: RTL and testbench

Sequencer that drives the nco block through a programmed stepped-frequency sweep. It owns the nco control inputs (En, FCW, selXY, selSign). For each sweep step it loads an FCW and waits out the CORDIC pipeline flush. It then forwards a fixed number of valid nco samples downstream and advances FCW. It sits between a host/config register block and the nco instance and reports busy/done to the host.

---
 rtl/nco_sweep_ctrl.sv | 148 ++++++++++++++
 tb/tb_nco_sweep_ctrl.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nco_sweep_ctrl.sv
// Stepped-frequency sweep sequencer for the nco: loads each FCW, waits out the
// CORDIC pipeline flush, forwards a fixed number of samples, then advances FCW.
module nco_sweep_ctrl #(
    parameter int FCW_W     = 20,
    parameter int CNT_W     = 16,
    parameter int DOUT_W    = 12,
    parameter int FLUSH_LEN = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [FCW_W-1:0]  cfg_fcw_start,
    input  logic [FCW_W-1:0]  cfg_fcw_step,
    input  logic [CNT_W-1:0]  cfg_nsteps,
    input  logic [CNT_W-1:0]  cfg_dwell,
    input  logic              cfg_selXY,
    input  logic              cfg_selSign,
    input  logic              nco_vld,
    input  logic [DOUT_W-1:0] nco_dout,
    output logic              nco_en,
    output logic [FCW_W-1:0]  nco_fcw,
    output logic              nco_selXY,
    output logic              nco_selSign,
    output logic              smp_vld,
    output logic [DOUT_W-1:0] smp_data,
    output logic [CNT_W-1:0]  step_idx,
    output logic              busy,
    output logic              done
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FLUSH = 2'd1;
    localparam logic [1:0] S_DWELL = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam int              FL_W    = $clog2(FLUSH_LEN + 1);
    localparam logic [FL_W-1:0] FL_LAST = FL_W'(FLUSH_LEN - 1);

    logic [1:0]              state;
    logic [FL_W-1:0]         fcnt;
    logic [CNT_W-1:0]        dcnt;
    logic [CNT_W-1:0]        nsteps_r;
    logic [CNT_W-1:0]        dwell_r;
    logic signed [FCW_W-1:0] step_r;
    logic                    last_smp;
    logic                    last_step;

    // FCW arithmetic is modulo 2^FCW_W; a negative step simply wraps downward.
    function automatic logic [FCW_W-1:0] fcw_wrap_add(input logic [FCW_W-1:0] fcw,
                                                      input logic signed [FCW_W-1:0] inc);
        fcw_wrap_add = fcw + $unsigned(inc);
    endfunction

    assign last_smp  = (dcnt == dwell_r - CNT_W'(1));
    assign last_step = (step_idx == nsteps_r - CNT_W'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            fcnt        <= '0;
            dcnt        <= '0;
            nsteps_r    <= '0;
            dwell_r     <= '0;
            step_r      <= '0;
            nco_en      <= 1'b0;
            nco_fcw     <= '0;
            nco_selXY   <= 1'b0;
            nco_selSign <= 1'b0;
            smp_vld     <= 1'b0;
            smp_data    <= '0;
            step_idx    <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            smp_vld <= 1'b0;
            done    <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start && !abort) begin
                        nsteps_r    <= cfg_nsteps;
                        dwell_r     <= cfg_dwell;
                        step_r      <= $signed(cfg_fcw_step);
                        nco_selXY   <= cfg_selXY;
                        nco_selSign <= cfg_selSign;
                        if (cfg_nsteps == '0 || cfg_dwell == '0) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else begin
                            nco_fcw  <= cfg_fcw_start;
                            nco_en   <= 1'b1;
                            busy     <= 1'b1;
                            step_idx <= '0;
                            fcnt     <= '0;
                            dcnt     <= '0;
                            state    <= S_FLUSH;
                        end
                    end
                end
                S_FLUSH: begin
                    if (abort) begin
                        nco_en <= 1'b0;
                        busy   <= 1'b0;
                        state  <= S_IDLE;
                    end else if (fcnt == FL_LAST) begin
                        state <= S_DWELL;
                    end else begin
                        fcnt <= fcnt + FL_W'(1);
                    end
                end
                S_DWELL: begin
                    // abort takes priority, so a sample arriving with it is dropped
                    if (abort) begin
                        nco_en <= 1'b0;
                        busy   <= 1'b0;
                        state  <= S_IDLE;
                    end else if (nco_vld) begin
                        smp_vld  <= 1'b1;
                        smp_data <= nco_dout;
                        if (last_smp) begin
                            if (last_step) begin
                                nco_en <= 1'b0;
                                busy   <= 1'b0;
                                done   <= 1'b1;
                                state  <= S_DONE;
                            end else begin
                                nco_fcw  <= fcw_wrap_add(nco_fcw, step_r);
                                step_idx <= step_idx + CNT_W'(1);
                                dcnt     <= '0;
                                fcnt     <= '0;
                                state    <= S_FLUSH;
                            end
                        end else begin
                            dcnt <= dcnt + CNT_W'(1);
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nco_sweep_ctrl.sv
// Bench for nco_sweep_ctrl: directed scenarios plus randomized sweeps, each checked
// cycle by cycle against an expected timeline derived from the sweep rules.
module tb_nco_sweep_ctrl;

    localparam int FL   = 10;
    localparam int MAXC = 1024;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        abort;
    logic [19:0] cfg_fcw_start;
    logic [19:0] cfg_fcw_step;
    logic [15:0] cfg_nsteps;
    logic [15:0] cfg_dwell;
    logic        cfg_selXY;
    logic        cfg_selSign;
    logic        nco_vld;
    logic [11:0] nco_dout;
    logic        nco_en;
    logic [19:0] nco_fcw;
    logic        nco_selXY;
    logic        nco_selSign;
    logic        smp_vld;
    logic [11:0] smp_data;
    logic [15:0] step_idx;
    logic        busy;
    logic        done;

    nco_sweep_ctrl #(
        .FCW_W(20), .CNT_W(16), .DOUT_W(12), .FLUSH_LEN(FL)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .cfg_fcw_start(cfg_fcw_start), .cfg_fcw_step(cfg_fcw_step),
        .cfg_nsteps(cfg_nsteps), .cfg_dwell(cfg_dwell),
        .cfg_selXY(cfg_selXY), .cfg_selSign(cfg_selSign),
        .nco_vld(nco_vld), .nco_dout(nco_dout),
        .nco_en(nco_en), .nco_fcw(nco_fcw),
        .nco_selXY(nco_selXY), .nco_selSign(nco_selSign),
        .smp_vld(smp_vld), .smp_data(smp_data),
        .step_idx(step_idx), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;

    bit          vld_a  [MAXC];
    logic [11:0] dout_a [MAXC];
    bit          e_vld  [MAXC];
    logic [11:0] e_data [MAXC];
    bit          e_busy [MAXC];
    bit          e_done [MAXC];
    logic [19:0] e_fcw  [MAXC];
    logic [15:0] e_step [MAXC];

    logic [19:0] last_fcw  = '0;
    logic [15:0] last_step = '0;
    logic        exp_sx    = 1'b0;
    logic        exp_ss    = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, " busy"}, 32'(busy), 32'd0);
        chk({tag, " nco_en"}, 32'(nco_en), 32'd0);
        chk({tag, " done"}, 32'(done), 32'd0);
        chk({tag, " smp_vld"}, 32'(smp_vld), 32'd0);
        chk({tag, " nco_fcw"}, 32'(nco_fcw), 32'(last_fcw));
        chk({tag, " step_idx"}, 32'(step_idx), 32'(last_step));
        chk({tag, " selXY"}, 32'(nco_selXY), 32'(exp_sx));
        chk({tag, " selSign"}, 32'(nco_selSign), 32'(exp_ss));
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " busy"}, 32'(busy), 32'd0);
        chk({tag, " nco_en"}, 32'(nco_en), 32'd0);
        chk({tag, " done"}, 32'(done), 32'd0);
        chk({tag, " smp_vld"}, 32'(smp_vld), 32'd0);
        chk({tag, " smp_data"}, 32'(smp_data), 32'd0);
        chk({tag, " nco_fcw"}, 32'(nco_fcw), 32'd0);
        chk({tag, " step_idx"}, 32'(step_idx), 32'd0);
        chk({tag, " selXY"}, 32'(nco_selXY), 32'd0);
        chk({tag, " selSign"}, 32'(nco_selSign), 32'd0);
    endtask

    // mode 0: nco_vld always 1, mode 1: toggling, otherwise random ~75% duty.
    task automatic run_sweep(input string name, input logic [19:0] fs, input logic [19:0] st,
                             input logic [15:0] ns, input logic [15:0] dw, input int mode,
                             input int abort_at, input int bstart_at, input logic sx, input logic ss);
        int          dcyc;
        int          pos;
        int          c;
        int          acc;
        int          last;
        int          cnt_dut;
        int          cnt_exp;
        logic [19:0] f;
        for (int i = 0; i < MAXC; i++) begin
            case (mode)
                0:       vld_a[i] = 1'b1;
                1:       vld_a[i] = i[0];
                default: vld_a[i] = ($urandom_range(0, 3) != 0);
            endcase
            dout_a[i] = 12'($urandom);
            e_vld[i]  = 1'b0;
            e_data[i] = '0;
            e_busy[i] = 1'b0;
            e_done[i] = 1'b0;
            e_fcw[i]  = last_fcw;
            e_step[i] = last_step;
        end
        // Timeline model: cycle k is the interval following clock edge k, edge 0 samples start.
        pos = 0;
        if (ns != 0 && dw != 0) begin
            f = fs;
            for (int s = 0; s < int'(ns); s++) begin
                f   = fs + st * 20'(s);
                c   = pos + FL;
                acc = 0;
                while (acc < int'(dw) && c < MAXC - 8) begin
                    if (vld_a[c]) begin
                        acc++;
                        e_vld[c + 1]  = 1'b1;
                        e_data[c + 1] = dout_a[c];
                    end
                    c++;
                end
                for (int k = pos; k < c; k++) begin
                    e_busy[k] = 1'b1;
                    e_fcw[k]  = f;
                    e_step[k] = 16'(s);
                end
                pos = c;
            end
            for (int k = pos; k < MAXC; k++) begin
                e_fcw[k]  = f;
                e_step[k] = ns - 16'd1;
            end
        end
        dcyc = pos;
        e_done[dcyc] = 1'b1;
        last = dcyc + 2;
        if (abort_at >= 0 && abort_at < dcyc) begin
            for (int k = abort_at + 1; k < MAXC; k++) begin
                e_busy[k] = 1'b0;
                e_vld[k]  = 1'b0;
                e_done[k] = 1'b0;
                e_fcw[k]  = e_fcw[abort_at];
                e_step[k] = e_step[abort_at];
            end
            last = abort_at + 4;
        end

        @(posedge clk); #1;
        cfg_fcw_start = fs;
        cfg_fcw_step  = st;
        cfg_nsteps    = ns;
        cfg_dwell     = dw;
        cfg_selXY     = sx;
        cfg_selSign   = ss;
        start         = 1'b1;
        abort         = 1'b0;
        @(posedge clk); #1;
        start   = 1'b0;
        cnt_dut = 0;
        cnt_exp = 0;
        for (int cy = 0; cy <= last; cy++) begin
            chk($sformatf("%s busy@%0d", name, cy), 32'(busy), 32'(e_busy[cy]));
            chk($sformatf("%s nco_en@%0d", name, cy), 32'(nco_en), 32'(e_busy[cy]));
            chk($sformatf("%s done@%0d", name, cy), 32'(done), 32'(e_done[cy]));
            chk($sformatf("%s smp_vld@%0d", name, cy), 32'(smp_vld), 32'(e_vld[cy]));
            if (e_vld[cy])
                chk($sformatf("%s smp_data@%0d", name, cy), 32'(smp_data), 32'(e_data[cy]));
            chk($sformatf("%s nco_fcw@%0d", name, cy), 32'(nco_fcw), 32'(e_fcw[cy]));
            chk($sformatf("%s step_idx@%0d", name, cy), 32'(step_idx), 32'(e_step[cy]));
            chk($sformatf("%s selXY@%0d", name, cy), 32'(nco_selXY), 32'(sx));
            chk($sformatf("%s selSign@%0d", name, cy), 32'(nco_selSign), 32'(ss));
            if (smp_vld === 1'b1) cnt_dut++;
            if (e_vld[cy]) cnt_exp++;
            nco_vld  = vld_a[cy];
            nco_dout = dout_a[cy];
            abort    = (cy == abort_at);
            if (cy == bstart_at) begin
                start         = 1'b1;
                cfg_fcw_start = 20'($urandom);
                cfg_fcw_step  = 20'($urandom);
                cfg_nsteps    = 16'($urandom_range(1, 9));
                cfg_dwell     = 16'($urandom_range(1, 9));
                cfg_selXY     = ~sx;
                cfg_selSign   = ~ss;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
        end
        chk({name, " sample count"}, 32'(cnt_dut), 32'(cnt_exp));
        nco_vld   = 1'b0;
        abort     = 1'b0;
        start     = 1'b0;
        last_fcw  = e_fcw[last];
        last_step = e_step[last];
        exp_sx    = sx;
        exp_ss    = ss;
    endtask

    initial begin
        rst           = 1'b1;
        start         = 1'b0;
        abort         = 1'b0;
        cfg_fcw_start = '0;
        cfg_fcw_step  = '0;
        cfg_nsteps    = '0;
        cfg_dwell     = '0;
        cfg_selXY     = 1'b0;
        cfg_selSign   = 1'b0;
        nco_vld       = 1'b0;
        nco_dout      = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset");
        rst = 1'b0;

        run_sweep("basic", 20'd100, 20'd50, 16'd3, 16'd4, 0, -1, -1, 1'b0, 1'b1);
        run_sweep("wrap_up", 20'hFFFF0, 20'h00020, 16'd2, 16'd3, 0, -1, -1, 1'b1, 1'b0);
        run_sweep("wrap_neg", 20'h00010, 20'hFFFF0, 16'd3, 16'd2, 2, -1, -1, 1'b1, 1'b1);
        run_sweep("degen_ns0", 20'h11111, 20'd7, 16'd0, 16'd5, 0, -1, -1, 1'b0, 1'b0);
        run_sweep("degen_dw0", 20'h22222, 20'd7, 16'd2, 16'd0, 0, -1, -1, 1'b1, 1'b0);
        run_sweep("gapped", 20'h0ABCD, 20'd3, 16'd1, 16'd3, 1, -1, -1, 1'b0, 1'b1);
        // Step 1 dwells from cycle 24; its 2nd sample is presented in cycle 25.
        run_sweep("abort", 20'd100, 20'd50, 16'd3, 16'd4, 0, 25, -1, 1'b1, 1'b1);

        @(posedge clk); #1;
        cfg_fcw_start = 20'h55555;
        cfg_nsteps    = 16'd2;
        cfg_dwell     = 16'd2;
        cfg_selXY     = 1'b0;
        cfg_selSign   = 1'b0;
        start         = 1'b1;
        abort         = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        abort = 1'b0;
        chk_idle("start_abort c0");
        @(posedge clk); #1;
        chk_idle("start_abort c1");

        run_sweep("start_busy", 20'd300, 20'd9, 16'd2, 16'd4, 0, -1, 12, 1'b0, 1'b1);

        @(posedge clk); #1;
        cfg_fcw_start = 20'h12345;
        cfg_fcw_step  = 20'd1;
        cfg_nsteps    = 16'd2;
        cfg_dwell     = 16'd4;
        cfg_selXY     = 1'b1;
        cfg_selSign   = 1'b1;
        start         = 1'b1;
        @(posedge clk); #1;
        start   = 1'b0;
        nco_vld = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        chk("rst_mid busy before", 32'(busy), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst     = 1'b0;
        nco_vld = 1'b0;
        chk_all_zero("rst_mid");
        last_fcw  = '0;
        last_step = '0;
        exp_sx    = 1'b0;
        exp_ss    = 1'b0;
        run_sweep("after_rst", 20'h00777, 20'd5, 16'd2, 16'd3, 0, -1, -1, 1'b1, 1'b0);

        for (int r = 0; r < 8; r++) begin
            run_sweep($sformatf("rand%0d", r), 20'($urandom), 20'($urandom),
                      16'($urandom_range(1, 4)), 16'($urandom_range(1, 6)),
                      int'($urandom_range(0, 2)), -1, -1,
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
